// File: rtl/riscv_pkg.sv
// Shared RV32 control definitions: FSM states, mux select encodings,
// opcode values, instruction field positions and an opcode classifier.
package riscv_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4   = 2'd0,
        PC_IMM     = 2'd1,
        PC_RS1_IMM = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    typedef enum logic [2:0] {
        CL_OP_IMM,
        CL_OP,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_ILLEGAL
    } op_class_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned RD_MSB     = 11;

    function automatic op_class_e decode_class(input logic [6:0] opc);
        case (opc)
            OPC_OP_IMM: return CL_OP_IMM;
            OPC_OP:     return CL_OP;
            OPC_LOAD:   return CL_LOAD;
            OPC_STORE:  return CL_STORE;
            OPC_BRANCH: return CL_BRANCH;
            OPC_JAL:    return CL_JAL;
            OPC_JALR:   return CL_JALR;
            default:    return CL_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for memory handshakes; expired flags the cycle in
// which the count would reach MEM_TIMEOUT.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CW = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
    localparam logic [CW:0] LIMIT = (CW + 1)'(MEM_TIMEOUT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Looks one count ahead so a handshake in the final cycle still wins.
    assign expired = ({1'b0, cnt_q} + (CW + 1)'(1)) >= LIMIT;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: fetch/decode/exec/mem/writeback sequencing
// with bounded memory handshakes and a sticky trap state.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic        branch_taken_i,
    output logic        imem_req_o,
    input  logic        imem_ready_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ready_i,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic        alu_src_imm_o,
    output logic        reg_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        trap_o,
    output logic [2:0]  state_o
);

    state_e    state_q, state_d;
    op_class_e cls;
    logic      rd_zero;
    logic      wait_inc;
    logic      timed_out;

    assign cls     = decode_class(instr_i[OPCODE_MSB:OPCODE_LSB]);
    assign rd_zero = (instr_i[RD_MSB:RD_LSB] == '0);
    assign state_o = state_q;

    // Any cycle not spent waiting on a request clears the counter.
    assign wait_inc = (imem_req_o && !imem_ready_i) || (dmem_req_o && !dmem_ready_i);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!wait_inc),
        .inc     (wait_inc),
        .expired (timed_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        imem_req_o    = 1'b0;
        dmem_req_o    = 1'b0;
        dmem_we_o     = 1'b0;
        ir_we_o       = 1'b0;
        pc_we_o       = 1'b0;
        pc_sel_o      = PC_PLUS4;
        alu_src_imm_o = 1'b0;
        reg_we_o      = 1'b0;
        wb_sel_o      = WB_ALU;
        trap_o        = 1'b0;
        // Outputs stay quiet while reset is held, even though state is FETCH.
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    imem_req_o = 1'b1;
                    if (imem_ready_i) begin
                        ir_we_o = 1'b1;
                        state_d = DECODE;
                    end else if (timed_out) begin
                        state_d = TRAP;
                    end
                end
                DECODE: begin
                    state_d = (cls == CL_ILLEGAL) ? TRAP : EXEC;
                end
                EXEC: begin
                    alu_src_imm_o = cls inside {CL_OP_IMM, CL_LOAD, CL_STORE, CL_JALR};
                    case (cls)
                        CL_BRANCH: begin
                            pc_we_o  = 1'b1;
                            pc_sel_o = branch_taken_i ? PC_IMM : PC_PLUS4;
                            state_d  = FETCH;
                        end
                        CL_LOAD, CL_STORE: state_d = MEM;
                        default:           state_d = WB;
                    endcase
                end
                MEM: begin
                    dmem_req_o = 1'b1;
                    dmem_we_o  = (cls == CL_STORE);
                    if (dmem_ready_i) begin
                        if (cls == CL_STORE) begin
                            pc_we_o = 1'b1;
                            state_d = FETCH;
                        end else begin
                            state_d = WB;
                        end
                    end else if (timed_out) begin
                        state_d = TRAP;
                    end
                end
                WB: begin
                    reg_we_o = !rd_zero;
                    pc_we_o  = 1'b1;
                    case (cls)
                        CL_LOAD: wb_sel_o = WB_LOAD;
                        CL_JAL:  begin wb_sel_o = WB_PC4; pc_sel_o = PC_IMM;     end
                        CL_JALR: begin wb_sel_o = WB_PC4; pc_sel_o = PC_RS1_IMM; end
                        default: ;
                    endcase
                    state_d = FETCH;
                end
                TRAP: begin
                    trap_o = 1'b1;
                end
                default: state_d = TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle output traces compared
// against a transaction-level model of the instruction lifecycle.
module tb_multicycle_ctrl;
    import riscv_pkg::*;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_i = '0;
    logic        branch_taken_i = 1'b0;
    logic        imem_ready_i = 1'b0;
    logic        dmem_ready_i = 1'b0;
    logic        imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o;
    logic [1:0]  pc_sel_o, wb_sel_o;
    logic        alu_src_imm_o, reg_we_o, trap_o;
    logic [2:0]  state_o;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_i        (instr_i),
        .branch_taken_i (branch_taken_i),
        .imem_req_o     (imem_req_o),
        .imem_ready_i   (imem_ready_i),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_ready_i   (dmem_ready_i),
        .ir_we_o        (ir_we_o),
        .pc_we_o        (pc_we_o),
        .pc_sel_o       (pc_sel_o),
        .alu_src_imm_o  (alu_src_imm_o),
        .reg_we_o       (reg_we_o),
        .wb_sel_o       (wb_sel_o),
        .trap_o         (trap_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, ir_we, dmem_req, dmem_we, pc_we;
        logic [1:0] pc_sel;
        logic       alu_imm, reg_we;
        logic [1:0] wb_sel;
        logic       trap;
    } obs_t;

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Select fields are only meaningful alongside their strobe.
    function automatic obs_t sample();
        obs_t o;
        o.st       = state_o;
        o.imem_req = imem_req_o;
        o.ir_we    = ir_we_o;
        o.dmem_req = dmem_req_o;
        o.dmem_we  = dmem_we_o;
        o.pc_we    = pc_we_o;
        o.pc_sel   = pc_we_o ? pc_sel_o : 2'd0;
        o.alu_imm  = alu_src_imm_o;
        o.reg_we   = reg_we_o;
        o.wb_sel   = reg_we_o ? wb_sel_o : 2'd0;
        o.trap     = trap_o;
        return o;
    endfunction

    function automatic void push_trap();
        obs_t e;
        for (int k = 0; k < 3; k++) begin
            e = '0; e.st = TRAP; e.trap = 1'b1;
            exp_q.push_back(e);
        end
    endfunction

    // Lifecycle model: fd/md are the number of cycles the memory stalls.
    function automatic int model(input logic [31:0] ins, input bit taken,
                                 input int unsigned fd, input int unsigned md);
        obs_t e;
        int n = 0;
        logic [6:0] op = ins[6:0];
        bit is_load  = (op == 7'h03);
        bit is_store = (op == 7'h23);
        bit is_br    = (op == 7'h63);
        bit is_jal   = (op == 7'h6F);
        bit is_jalr  = (op == 7'h67);
        bit legal    = is_load || is_store || is_br || is_jal || is_jalr ||
                       (op == 7'h13) || (op == 7'h33);
        for (int unsigned w = 0; w < fd && w < TMO; w++) begin
            e = '0; e.st = FETCH; e.imem_req = 1'b1; exp_q.push_back(e); n++;
        end
        if (fd >= TMO) begin push_trap(); return n + 3; end
        e = '0; e.st = FETCH; e.imem_req = 1'b1; e.ir_we = 1'b1; exp_q.push_back(e); n++;
        e = '0; e.st = DECODE; exp_q.push_back(e); n++;
        if (!legal) begin push_trap(); return n + 3; end
        e = '0; e.st = EXEC;
        e.alu_imm = (op == 7'h13) || is_load || is_store || is_jalr;
        if (is_br) begin e.pc_we = 1'b1; e.pc_sel = taken ? 2'd1 : 2'd0; end
        exp_q.push_back(e); n++;
        if (is_br) return n;
        if (is_load || is_store) begin
            for (int unsigned w = 0; w < md && w < TMO; w++) begin
                e = '0; e.st = MEM; e.dmem_req = 1'b1; e.dmem_we = is_store;
                exp_q.push_back(e); n++;
            end
            if (md >= TMO) begin push_trap(); return n + 3; end
            e = '0; e.st = MEM; e.dmem_req = 1'b1; e.dmem_we = is_store; e.pc_we = is_store;
            exp_q.push_back(e); n++;
            if (is_store) return n;
        end
        e = '0; e.st = WB; e.pc_we = 1'b1;
        e.reg_we = (ins[11:7] != 5'd0);
        if (e.reg_we) e.wb_sel = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        e.pc_sel = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        exp_q.push_back(e); n++;
        return n;
    endfunction

    // Memory responder: ready after the requested stall, random when idle.
    task automatic run_instr(input logic [31:0] ins, input bit taken,
                             input int unsigned fd, input int unsigned md, input int n);
        int unsigned fc = 0;
        int unsigned mc = 0;
        obs_t o;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin instr_i = ins; branch_taken_i = taken; end
            imem_ready_i = imem_req_o ? (fc >= fd) : 1'($urandom);
            dmem_ready_i = dmem_req_o ? (mc >= md) : 1'($urandom);
            #1;
            o = sample();
            obs_q.push_back(o);
            if (o.imem_req) fc = imem_ready_i ? 0 : fc + 1;
            if (o.dmem_req) mc = dmem_ready_i ? 0 : mc + 1;
        end
    endtask

    task automatic do_instr(input logic [31:0] ins, input bit taken,
                            input int unsigned fd, input int unsigned md);
        int n;
        n = model(ins, taken, fd, md);
        run_instr(ins, taken, fd, md, n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e;
        e = '0; e.st = FETCH;
        #2;
        n_checks++;
        if (sample() !== e) $display("FAIL reset_outputs: got %h required %h", sample(), e);
        else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        n_checks++;
        if ({imem_req_o, state_o} !== {1'b1, 3'(FETCH)})
            $display("FAIL reset_release: got req=%b st=%0d required req=1 st=%0d", imem_req_o, state_o, FETCH);
        else n_pass++;
    endtask

    task automatic test_alu();
        exp_q.delete(); obs_q.delete();
        do_instr(32'h0050_0093, 1'b0, 0, 0);
        do_instr(32'h0020_81B3, 1'b0, 2, 0);
        do_instr(32'h0000_0013, 1'b0, 1, 0);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL alu cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if ({obs_q[3].st, obs_q[3].reg_we, obs_q[4].st} !== {3'(WB), 1'b1, 3'(FETCH)})
            $display("FAIL addi_timing: got %0d/%b/%0d required %0d/1/%0d", obs_q[3].st, obs_q[3].reg_we, obs_q[4].st, WB, FETCH);
        else n_pass++;
    endtask

    task automatic test_load_store();
        int req_cycles = 0;
        exp_q.delete(); obs_q.delete();
        do_instr(32'h0000_A103, 1'b0, 1, 3);
        do_instr(32'h0020_A023, 1'b0, 0, 2);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL load_store cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        for (int i = 0; i < 8; i++) if (obs_q[i].dmem_req) req_cycles++;
        n_checks++;
        if (req_cycles != 4) $display("FAIL lw_req_cycles: got %0d required 4", req_cycles);
        else n_pass++;
    endtask

    task automatic test_branch();
        exp_q.delete(); obs_q.delete();
        do_instr(32'h0020_8463, 1'b1, 0, 0);
        do_instr(32'h0020_8463, 1'b0, 1, 0);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL branch cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_jumps();
        exp_q.delete(); obs_q.delete();
        do_instr(32'h0080_006F, 1'b0, 0, 0);
        do_instr(32'h0000_80E7, 1'b0, 0, 0);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL jumps cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_traps();
        exp_q.delete(); obs_q.delete();
        do_instr(32'h0000_007F, 1'b0, 0, 0);
        do_reset();
        do_instr(32'h0050_0093, 1'b0, 4, 0);
        do_reset();
        do_instr(32'h0050_0093, 1'b0, 3, 0);
        do_instr(32'h0000_A103, 1'b0, 0, 4);
        do_reset();
        do_instr(32'h0020_A023, 1'b0, 0, 3);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL traps cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_wait();
        obs_t e;
        exp_q.delete(); obs_q.delete();
        void'(model(32'h0000_A103, 1'b0, 0, 99));
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        run_instr(32'h0000_A103, 1'b0, 0, 99, 4);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL mid_wait cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        e = '0; e.st = FETCH;
        n_checks++;
        if (sample() !== e) $display("FAIL mid_wait_async: got %h required %h", sample(), e);
        else n_pass++;
        imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        n_checks++;
        if ({imem_req_o, dmem_req_o, state_o} !== {1'b1, 1'b0, 3'(FETCH)})
            $display("FAIL mid_wait_release: got %b%b st=%0d required 10 st=%0d", imem_req_o, dmem_req_o, state_o, FETCH);
        else n_pass++;
        exp_q.delete(); obs_q.delete();
        do_instr(32'h0000_A103, 1'b0, 0, 1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL after_reset cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  ops [7] = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
        logic [31:0] r;
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 60; k++) begin
            r = $urandom();
            do_instr({r[31:7], ops[$urandom_range(6)]}, 1'($urandom),
                     $urandom_range(TMO - 1), $urandom_range(TMO - 1));
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL random cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_jumps();
        test_traps();
        test_reset_mid_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 255, max wait cycles for any memory handshake before trap.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 instr_i  in  32  current instruction register contents from datapath.
REQ-005 branch_taken_i  in  1  datapath branch comparison result.
REQ-006 imem_req_o / imem_ready_i  out/in  1/1  instruction fetch handshake.
REQ-007 dmem_req_o / dmem_we_o / dmem_ready_i  out/out/in  1/1/1  data memory handshake, we=1 store.
REQ-008 ir_we_o  out  1  latch fetched word into IR.
REQ-009 pc_we_o  out  1  update PC; pc_sel_o  out  2  0=PC+4, 1=PC+imm, 2=rs1+imm (JALR).
REQ-010 alu_src_imm_o  out  1  ALU operand B is immediate.
REQ-011 reg_we_o  out  1  register write strobe; wb_sel_o  out  2  0=ALU, 1=load data, 2=PC+4.
REQ-012 trap_o  out  1  sticky fault flag; state_o  out  3  current state encoding, debug.

Function
REQ-013 States: FETCH, DECODE, EXEC, MEM, WB, TRAP; encoding is state_o.
REQ-014 FETCH: imem_req_o=1 until a cycle with imem_req_o&imem_ready_i; that cycle ir_we_o=1, next DECODE.
REQ-015 DECODE: opcode=instr_i[6:0]; OP_IMM/OP/LOAD/STORE/BRANCH/JAL/JALR go EXEC; any other opcode goes TRAP.
REQ-016 EXEC, one cycle: alu_src_imm_o=1 for OP_IMM/LOAD/STORE/JALR, 0 otherwise; LOAD/STORE go MEM; all others go WB.
REQ-017 EXEC BRANCH: pc_we_o=1 with pc_sel_o=1 if branch_taken_i else 0; next FETCH, no register write.
REQ-018 MEM: dmem_req_o=1, dmem_we_o=1 for STORE; held until dmem_req_o&dmem_ready_i; then LOAD goes WB, STORE asserts pc_we_o (pc_sel_o=0) that cycle and goes FETCH.
REQ-019 WB, one cycle: reg_we_o=1 unless rd=instr_i[11:7]==0; wb_sel_o=1 LOAD, 2 JAL/JALR, 0 otherwise; pc_we_o=1 with pc_sel_o=1 JAL, 2 JALR, 0 otherwise; next FETCH.
REQ-020 Request outputs shall not drop while waiting; ready while req=0 is ignored.
REQ-021 Wait counter (8-bit min, saturating) clears on entering FETCH or MEM, increments each waiting cycle; count reaching MEM_TIMEOUT without handshake goes TRAP.
REQ-022 Handshake completing in the cycle the counter reaches MEM_TIMEOUT completes normally, no trap.
REQ-023 TRAP: all strobes and requests 0, trap_o=1; exits only via reset.
REQ-024 At most one of pc_we_o, ir_we_o, reg_we_o pulses per state except WB (reg_we_o+pc_we_o) and STORE completion; every strobe is exactly one cycle.
REQ-025 All outputs combinational from registered state, counter and inputs; no input-to-state latency beyond one clock.

Reset
REQ-026 rst_n low asynchronously forces state FETCH, counter 0, trap_o 0, all strobes/requests 0.
REQ-027 Reset mid-handshake abandons the transfer; first cycle after release drives imem_req_o=1.

Structure
REQ-028 State enum typedef, pc_sel/wb_sel encodings in shared riscv_pkg; opcode classes and field bit positions taken from riscv_pkg.
REQ-029 One sub-module natural: mem_wait_timer (saturating counter, timeout compare).

Verification
REQ-030 ADDI x1 (0x00500093), imem_ready_i tied 1 -> FETCH,DECODE,EXEC,WB; reg_we_o, wb_sel 0, pc_sel 0 in cycle 4; back in FETCH cycle 5.
REQ-031 LW with dmem_ready_i delayed 3 cycles -> dmem_req_o high 4 cycles, then WB with wb_sel 1; SW -> no reg_we_o, dmem_we_o=1, pc_we_o on handshake.
REQ-032 BEQ, branch_taken_i=1 then 0 -> pc_sel_o 1 then 0, single pc_we_o each, reg_we_o never asserted.
REQ-033 JAL rd=x0 -> reg_we_o 0, pc_sel_o 1; JALR rd=x1 -> reg_we_o 1, wb_sel 2, pc_sel 2.
REQ-034 Opcode 0x7F -> TRAP after DECODE, trap_o stuck until rst_n; imem_ready_i held 0 with MEM_TIMEOUT=4 -> TRAP at 4th wait, ready on that cycle instead -> normal fetch.
REQ-035 rst_n pulsed low during MEM wait -> outputs zero immediately, imem_req_o=1 first cycle after release.
